led_frame_sequencer: RTL and testbench

Parametrised frame sequencer for serial-LED (WS2812-class) matrices and strips. Steps through every pixel of a frame, presenting the pixel address for the channel-value read, pulsing the shift-register load, and holding the transmit window for one pixel's worth of bit slots. After the last pixel it holds the line idle for the latch gap, then advances the frame index. Generalises the fixed 64-pixel/24-bit/32-frame controller with configurable geometry, non-power-of-two frame wrap, run/step playback control and status outputs.

---
 rtl/led_seq_pkg.sv | 17 +
 rtl/led_seq_down_counter.sv | 26 ++
 rtl/led_frame_sequencer.sv | 112 +++++++++++
 tb/tb_led_frame_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared state encoding and width helpers for the LED frame sequencer
package led_seq_pkg;

   typedef enum logic [2:0] {
      ST_STOP  = 3'd0,
      ST_READ  = 3'd1,
      ST_LOAD  = 3'd2,
      ST_SHIFT = 3'd3,
      ST_IDLE  = 3'd4
   } led_seq_state_t;

   // Counter width that holds values 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/led_seq_down_counter.sv
// rtl/led_seq_down_counter.sv - loadable down counter with zero flag, saturating at zero
module led_seq_down_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             zero
);

   always_ff @(negedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - WIDTH'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/led_frame_sequencer.sv
// rtl/led_frame_sequencer.sv - pixel/frame sequencer for serial-LED chains
// Optional reverse playback (dir input) is enabled by defining LED_SEQ_REVERSE_EN.
module led_frame_sequencer
   import led_seq_pkg::*;
#(
   parameter int NUM_PIXELS     = 64,
   parameter int BITS_PER_PIXEL = 24,
   parameter int CYCLES_PER_BIT = 15,
   parameter int IDLE_CYCLES    = 8000000,
   parameter int NUM_FRAMES     = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          run,
   input  logic                          step,
`ifdef LED_SEQ_REVERSE_EN
   input  logic                          dir,
`endif
   output logic                          load_sreg,
   output logic                          transmit_pixel,
   output logic [$clog2(NUM_PIXELS)-1:0] pixel,
   output logic [$clog2(NUM_FRAMES)-1:0] frame,
   output logic                          busy,
   output logic                          frame_done
);

   localparam int PIX_W     = $clog2(NUM_PIXELS);
   localparam int FRM_W     = $clog2(NUM_FRAMES);
   localparam int SHIFT_LEN = BITS_PER_PIXEL * CYCLES_PER_BIT;
   localparam int SHIFT_W   = cnt_width(SHIFT_LEN);
   localparam int IDLE_W    = cnt_width(IDLE_CYCLES);

   led_seq_state_t     state;
   led_seq_state_t     state_next;
   logic               shift_zero;
   logic               idle_zero;
   logic               last_pixel;
   logic               last_shift;
   logic               last_idle;
   logic [FRM_W-1:0]   frame_next;
   logic [SHIFT_W-1:0] shift_count;
   logic [IDLE_W-1:0]  idle_count;

   assign last_pixel = (pixel == PIX_W'(NUM_PIXELS - 1));
   assign last_shift = (state == ST_SHIFT) && shift_zero;
   assign last_idle  = (state == ST_IDLE) && idle_zero;

   // Loaded during LOAD so the first SHIFT cycle already sees the full slot count.
   led_seq_down_counter #(.WIDTH(SHIFT_W)) u_shift_cnt (
      .clk        (clk),
      .rst        (rst),
      .load       (state == ST_LOAD),
      .dec        (state == ST_SHIFT),
      .load_value (SHIFT_W'(SHIFT_LEN - 1)),
      .count      (shift_count),
      .zero       (shift_zero)
   );

   // Loaded on the last slot of the last pixel, i.e. on the edge entering IDLE.
   led_seq_down_counter #(.WIDTH(IDLE_W)) u_idle_cnt (
      .clk        (clk),
      .rst        (rst),
      .load       (last_shift && last_pixel),
      .dec        (state == ST_IDLE),
      .load_value (IDLE_W'(IDLE_CYCLES - 1)),
      .count      (idle_count),
      .zero       (idle_zero)
   );

   always_comb begin
      state_next = state;
      case (state)
         ST_STOP:  if (run || step) state_next = ST_READ;
         ST_READ:  state_next = ST_LOAD;
         ST_LOAD:  state_next = ST_SHIFT;
         ST_SHIFT: if (shift_zero) state_next = last_pixel ? ST_IDLE : ST_READ;
         ST_IDLE:  if (idle_zero) state_next = run ? ST_READ : ST_STOP;
         default:  state_next = ST_STOP;
      endcase
   end

   always_comb begin
      frame_next = (frame == FRM_W'(NUM_FRAMES - 1)) ? '0 : frame + FRM_W'(1);
`ifdef LED_SEQ_REVERSE_EN
      if (dir) begin
         frame_next = (frame == '0) ? FRM_W'(NUM_FRAMES - 1) : frame - FRM_W'(1);
      end
`endif
   end

   always_ff @(negedge clk) begin
      if (rst) begin
         state <= ST_STOP;
         pixel <= '0;
         frame <= '0;
      end else begin
         state <= state_next;
         if (last_shift) begin
            pixel <= last_pixel ? '0 : pixel + PIX_W'(1);
         end
         if (last_idle) begin
            frame <= frame_next;
         end
      end
   end

   assign load_sreg      = (state == ST_LOAD);
   assign transmit_pixel = (state == ST_SHIFT);
   assign busy           = (state != ST_STOP);
   assign frame_done     = last_idle;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// tb/tb_led_frame_sequencer.sv - directed self-checking bench for led_frame_sequencer
module tb_led_frame_sequencer;

   logic       clk = 1'b1;
   logic       rst = 1'b1;
   logic       run = 1'b0;
   logic       step = 1'b0;
`ifdef LED_SEQ_REVERSE_EN
   logic       dir = 1'b0;
`endif
   logic       load_sreg;
   logic       transmit_pixel;
   logic [1:0] pixel;
   logic [1:0] frame;
   logic       busy;
   logic       frame_done;

   int tests = 0;
   int fails = 0;

   int pix_val[16], pix_cyc[16], fr_val[8], fr_cyc[8], done_cyc[8];
   int n_pix, n_fr, n_done, n_load, bad_order, bad_len, first_txlen, busy_fall;

   always #5 clk = ~clk;

   led_frame_sequencer #(
      .NUM_PIXELS     (4),
      .BITS_PER_PIXEL (24),
      .CYCLES_PER_BIT (2),
      .IDLE_CYCLES    (10),
      .NUM_FRAMES     (3)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .run            (run),
      .step           (step),
`ifdef LED_SEQ_REVERSE_EN
      .dir            (dir),
`endif
      .load_sreg      (load_sreg),
      .transmit_pixel (transmit_pixel),
      .pixel          (pixel),
      .frame          (frame),
      .busy           (busy),
      .frame_done     (frame_done)
   );

   typedef struct {
      logic       rst;
      logic       run;
      logic       step;
      logic [7:0] exp;   // {load, tx, busy, done, pixel, frame}
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive inputs, let one active (falling) edge pass, then settle.
   task automatic apply(input logic r, input logic ru, input logic st);
      rst  = r;
      run  = ru;
      step = st;
      @(negedge clk);
      #1;
   endtask

   function automatic logic [7:0] outs();
      return {load_sreg, transmit_pixel, busy, frame_done, pixel, frame};
   endfunction

   task automatic sim(input int ncyc, input int run_until, input int step_a, input int step_b);
      logic       prev_load, prev_tx, prev_busy, prev_done;
      logic [1:0] prev_pix, prev_fr;
      int         txrun;
      n_pix = 0; n_fr = 0; n_done = 0; n_load = 0;
      bad_order = 0; bad_len = 0; first_txlen = 0; busy_fall = 0; txrun = 0;
      prev_load = load_sreg; prev_tx = transmit_pixel; prev_busy = busy;
      prev_done = frame_done; prev_pix = pixel; prev_fr = frame;
      for (int k = 1; k <= ncyc; k++) begin
         apply(1'b0, k <= run_until, (k == step_a) || (k == step_b));
         if (load_sreg) n_load++;
         if (transmit_pixel && !prev_tx && !prev_load) bad_order++;
         if (prev_load && !transmit_pixel) bad_order++;
         if (load_sreg && transmit_pixel) bad_order++;
         if (transmit_pixel) begin
            txrun++;
         end else if (prev_tx) begin
            if (first_txlen == 0) first_txlen = txrun;
            else if (txrun != first_txlen) bad_len++;
            txrun = 0;
         end
         if (pixel != prev_pix) begin
            if (!prev_tx || transmit_pixel) bad_order++;
            if (n_pix < 16) begin pix_val[n_pix] = int'(pixel); pix_cyc[n_pix] = k; n_pix++; end
         end
         if (frame != prev_fr) begin
            if (!prev_done) bad_order++;
            if (n_fr < 8) begin fr_val[n_fr] = int'(frame); fr_cyc[n_fr] = k; n_fr++; end
         end
         if (frame_done && n_done < 8) begin done_cyc[n_done] = k; n_done++; end
         if (prev_busy && !busy && busy_fall == 0) busy_fall = k;
         prev_load = load_sreg; prev_tx = transmit_pixel; prev_busy = busy;
         prev_done = frame_done; prev_pix = pixel; prev_fr = frame;
      end
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b0, 1'b0, 8'b0000_0000};
      vecs[1] = '{1'b0, 1'b0, 1'b0, 8'b0000_0000};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 8'b0010_0000};
      vecs[3] = '{1'b0, 1'b1, 1'b0, 8'b1010_0000};
      vecs[4] = '{1'b0, 1'b1, 1'b0, 8'b0110_0000};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 8'b0000_0000};
      vecs[6] = '{1'b0, 1'b0, 1'b1, 8'b0010_0000};
      vecs[7] = '{1'b0, 1'b0, 1'b0, 8'b1010_0000};
      vecs[8] = '{1'b0, 1'b0, 1'b1, 8'b0110_0000};
      vecs[9] = '{1'b0, 1'b0, 1'b0, 8'b0110_0000};

      for (int i = 0; i < 10; i++) begin
         apply(vecs[i].rst, vecs[i].run, vecs[i].step);
         check($sformatf("vec%0d", i), int'(outs()), int'(vecs[i].exp));
      end

      // Continuous playback over three frames.
      apply(1'b1, 1'b0, 1'b0);
      sim(640, 640, 0, 0);
      check("run_pix1", pix_val[0], 1);
      check("run_pix2", pix_val[1], 2);
      check("run_pix3", pix_val[2], 3);
      check("run_pix0", pix_val[3], 0);
      check("run_pix1_cyc", pix_cyc[0], 51);
      check("run_pix0_cyc", pix_cyc[3], 201);
      check("run_txlen", first_txlen, 48);
      check("run_badlen", bad_len, 0);
      check("run_order", bad_order, 0);
      check("run_ndone", n_done, 3);
      check("run_done0", done_cyc[0], 210);
      check("run_done1", done_cyc[1], 420);
      check("run_done2", done_cyc[2], 630);
      check("run_fr1", fr_val[0], 1);
      check("run_fr2", fr_val[1], 2);
      check("run_fr0", fr_val[2], 0);
      check("run_fr_cyc", fr_cyc[2], 631);
      check("run_nload", n_load, 13);

      // Single step (with run also high on the first cycle), plus an ignored mid-frame step.
      apply(1'b1, 1'b0, 1'b0);
      sim(300, 1, 1, 100);
      check("step_ndone", n_done, 1);
      check("step_done", done_cyc[0], 210);
      check("step_busyfall", busy_fall, 211);
      check("step_nload", n_load, 4);
      check("step_frame", int'(frame), 1);
      check("step_busy", int'(busy), 0);
      check("step_order", bad_order, 0);

      // run dropped during pixel 1: frame and latch gap still complete.
      apply(1'b1, 1'b0, 1'b0);
      sim(300, 60, 0, 0);
      check("drop_ndone", n_done, 1);
      check("drop_done", done_cyc[0], 210);
      check("drop_busyfall", busy_fall, 211);
      check("drop_nload", n_load, 4);
      check("drop_npix", n_pix, 4);
      check("drop_frame", int'(frame), 1);

      // Reset while shifting pixel 2.
      apply(1'b1, 1'b0, 1'b0);
      sim(110, 110, 0, 0);
      check("rst_pre_tx", int'(transmit_pixel), 1);
      check("rst_pre_pix", int'(pixel), 2);
      apply(1'b1, 1'b1, 1'b0);
      check("rst_outs", int'(outs()), 0);
      apply(1'b0, 1'b0, 1'b0);
      check("rst_stop", int'(outs()), 0);

`ifdef LED_SEQ_REVERSE_EN
      dir = 1'b1;
      apply(1'b1, 1'b0, 1'b0);
      sim(640, 640, 0, 0);
      check("rev_fr2", fr_val[0], 2);
      check("rev_fr1", fr_val[1], 1);
      check("rev_fr0", fr_val[2], 0);
      check("rev_nfr", n_fr, 3);
      dir = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
